// File: rtl/tribus_arbiter.sv
// tribus_arbiter: round-robin owner sequencer for a shared tri-state bus.
// Produces one-hot bufif1 enables with an all-off turnaround between owners
// and a bounded hold time per grant.
// Optional bus keeper: define TRIBUS_KEEPER_EN to drive the last owned value
// onto the bus while nobody owns it; otherwise the bus relies on an external pull.
module tribus_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int HOLD_MAX = 8,
  parameter int TURN     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  input  logic [W-1:0]         bus_in,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         oe,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 timeout,
  output logic                 keep_oe,
  output logic [W-1:0]         keep_val
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam int TW = $clog2(TURN + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   rr_ptr, rr_d;
  logic [CW-1:0]   hold_cnt, hold_d;
  logic [TW-1:0]   turn_cnt, turn_d;
  logic [N-1:0]    grant_d;
  logic [IW-1:0]   owner_d;
  logic            busy_d, timeout_d;
  logic [IW-1:0]   winner;
  logic            at_max, vol_rel;

  // First requester at or above the pointer, wrapping from N-1 back to 0.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    logic          found;
    int            idx;
    w     = p;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(p) + i;
      if (idx >= N) idx = idx - N;
      if (!found && r[IW'(idx)]) begin
        w     = IW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign winner  = rr_pick(req, rr_ptr);
  assign at_max  = (hold_cnt == CW'(HOLD_MAX));
  // A voluntary release (done or dropped request) outranks the hold limit.
  assign vol_rel = done[owner] | ~req[owner];
  assign oe      = grant;

  // Next-state and next-output decode; everything visible is registered below.
  always_comb begin
    state_d   = state;
    rr_d      = rr_ptr;
    hold_d    = hold_cnt;
    turn_d    = turn_cnt;
    grant_d   = grant;
    owner_d   = owner;
    busy_d    = busy;
    timeout_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          grant_d = N'(1) << winner;
          owner_d = winner;
          busy_d  = 1'b1;
          hold_d  = CW'(1);
        end
      end
      ST_GRANT: begin
        if (vol_rel || at_max) begin
          state_d   = ST_TURN;
          grant_d   = '0;
          busy_d    = 1'b0;
          hold_d    = '0;
          turn_d    = TW'(1);
          rr_d      = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
          timeout_d = at_max & ~vol_rel;
        end else begin
          hold_d = hold_cnt + CW'(1);
        end
      end
      ST_TURN: begin
        if (turn_cnt == TW'(TURN)) begin
          state_d = ST_IDLE;
          turn_d  = '0;
        end else begin
          turn_d = turn_cnt + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops all enables immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      grant    <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_d;
      hold_cnt <= hold_d;
      turn_cnt <= turn_d;
      grant    <= grant_d;
      owner    <= owner_d;
      busy     <= busy_d;
      timeout  <= timeout_d;
    end
  end

`ifdef TRIBUS_KEEPER_EN
  // Keeper samples the bus while owned and drives it whenever no owner does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keep_oe  <= 1'b1;
      keep_val <= '0;
    end else begin
      keep_oe <= (state_d != ST_GRANT);
      if (state == ST_GRANT) keep_val <= bus_in;
    end
  end
`else
  logic unused_bus;
  assign unused_bus = ^bus_in;
  assign keep_oe    = 1'b0;
  assign keep_val   = '0;
`endif

endmodule

// File: tb/tb_tribus_arbiter.sv
// Scoreboard bench for tribus_arbiter (N=4, W=8, HOLD_MAX=8, TURN=1).
// Stimulus pushes hand-computed expected outputs tagged with a cycle number;
// the monitor pops and compares them on the falling edge (or just after an
// asynchronous reset edge).
module tb_tribus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [7:0] bus_in = '0;
  logic [3:0] grant, oe;
  logic [1:0] owner;
  logic       busy, timeout, keep_oe;
  logic [7:0] keep_val;

  tribus_arbiter #(.N(4), .W(8), .HOLD_MAX(8), .TURN(1)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .bus_in(bus_in),
    .grant(grant), .oe(oe), .owner(owner), .busy(busy), .timeout(timeout),
    .keep_oe(keep_oe), .keep_val(keep_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic [1:0] o;
    logic       b;
    logic       t;
    logic       koe;
    logic [7:0] kv;
    string      name;
  } exp_t;

  exp_t  q[$];
  int    cyc = 0;
  int    compared = 0;
  int    mismatched = 0;
  string tname = "reset";

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic koe_exp(input logic b);
`ifdef TRIBUS_KEEPER_EN
    return !b;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] kv_exp(input logic [7:0] v);
`ifdef TRIBUS_KEEPER_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic push_exp(input logic [3:0] g, input logic [1:0] o, input logic b,
                          input logic t, input logic [7:0] kv);
    exp_t e;
    e.cyc = cyc; e.g = g; e.o = o; e.b = b; e.t = t;
    e.koe = koe_exp(b); e.kv = kv_exp(kv); e.name = tname;
    q.push_back(e);
  endtask

  // Wait for the next rising edge, then record what the outputs must be now.
  task automatic cyc_chk(input logic [3:0] g, input logic [1:0] o, input logic b,
                         input logic t, input logic [7:0] kv);
    @(posedge clk);
    #1;
    push_exp(g, o, b, t, kv);
  endtask

  // Monitor: compares queued expectations and the enable invariants.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      compared++;
      if (!$onehot0(oe) || oe !== grant) begin
        mismatched++;
        $display("FAIL oe_onehot cyc=%0d: got oe=%b grant=%b, want zero/one-hot oe equal to grant",
                 cyc, oe, grant);
      end
      while (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        compared++;
        if (grant !== e.g || owner !== e.o || busy !== e.b || timeout !== e.t ||
            keep_oe !== e.koe || keep_val !== e.kv) begin
          mismatched++;
          $display("FAIL %s cyc=%0d: got grant=%b owner=%0d busy=%b timeout=%b keep_oe=%b keep_val=%h, want grant=%b owner=%0d busy=%b timeout=%b keep_oe=%b keep_val=%h",
                   e.name, cyc, grant, owner, busy, timeout, keep_oe, keep_val,
                   e.g, e.o, e.b, e.t, e.koe, e.kv);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    cyc_chk(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;

    // Single request, released by done
    tname = "single";
    req = 4'b0001;
    cyc_chk(4'b0001, 2'd0, 1'b1, 1'b0, 8'h00);
    done = 4'b0001;
    cyc_chk(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    done = 4'b0000;
    req  = 4'b0000;
    cyc_chk(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);

    // Contention on 1 and 3: each runs to HOLD_MAX, then rotation returns to 1
    tname = "contend";
    req = 4'b1010;
    for (int k = 0; k < 8; k++) cyc_chk(4'b0010, 2'd1, 1'b1, 1'b0, 8'h00);
    cyc_chk(4'b0000, 2'd1, 1'b0, 1'b1, 8'h00);
    cyc_chk(4'b0000, 2'd1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) cyc_chk(4'b1000, 2'd3, 1'b1, 1'b0, 8'h00);
    cyc_chk(4'b0000, 2'd3, 1'b0, 1'b1, 8'h00);
    cyc_chk(4'b0000, 2'd3, 1'b0, 1'b0, 8'h00);
    cyc_chk(4'b0010, 2'd1, 1'b1, 1'b0, 8'h00);
    done = 4'b0010;
    cyc_chk(4'b0000, 2'd1, 1'b0, 1'b0, 8'h00);
    done = 4'b0000;
    req  = 4'b0000;
    cyc_chk(4'b0000, 2'd1, 1'b0, 1'b0, 8'h00);

    // Lone requester 2 times out, then is re-granted
    tname = "timeout";
    req = 4'b0100;
    for (int k = 0; k < 8; k++) cyc_chk(4'b0100, 2'd2, 1'b1, 1'b0, 8'h00);
    cyc_chk(4'b0000, 2'd2, 1'b0, 1'b1, 8'h00);
    cyc_chk(4'b0000, 2'd2, 1'b0, 1'b0, 8'h00);

    // Re-grant; stray done from requester 0 is ignored; done on hold 8 wins
    tname = "done_at_max";
    for (int k = 1; k <= 8; k++) begin
      cyc_chk(4'b0100, 2'd2, 1'b1, 1'b0, 8'h00);
      if (k == 3) done = 4'b0001;
      if (k == 4) done = 4'b0000;
      if (k == 8) done = 4'b0100;
    end
    cyc_chk(4'b0000, 2'd2, 1'b0, 1'b0, 8'h00);
    done = 4'b0000;
    req  = 4'b0000;
    cyc_chk(4'b0000, 2'd2, 1'b0, 1'b0, 8'h00);

    // Pointer at 3 wraps to requester 0; async reset mid-grant
    tname = "async_reset";
    req = 4'b0001;
    cyc_chk(4'b0001, 2'd0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    #2;
    push_exp(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    cyc_chk(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;

    // After reset the pointer is 0, so all-requesting grants 0 first
    tname = "post_reset";
    req = 4'b1111;
    cyc_chk(4'b0001, 2'd0, 1'b1, 1'b0, 8'h00);
    req = 4'b0000;
    cyc_chk(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    cyc_chk(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);

    // Keeper holds the last owned bus value through turnaround and idle
    tname = "keeper";
    req    = 4'b0100;
    bus_in = 8'hA5;
    cyc_chk(4'b0100, 2'd2, 1'b1, 1'b0, 8'h00);
    done = 4'b0100;
    cyc_chk(4'b0000, 2'd2, 1'b0, 1'b0, 8'hA5);
    done   = 4'b0000;
    req    = 4'b0000;
    bus_in = 8'h00;
    cyc_chk(4'b0000, 2'd2, 1'b0, 1'b0, 8'hA5);
    cyc_chk(4'b0000, 2'd2, 1'b0, 1'b0, 8'hA5);

    // Every expectation must have been consumed
    repeat (2) @(negedge clk);
    #2;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
